// File: rtl/ram_word_sequencer_pkg.sv
// Shared definitions for the 16-bit word to 8-bit RAM sequencer.
// A core word is always exactly two RAM bytes, stored little-endian.
package ram_word_sequencer_pkg;

  localparam int ADDR_W = 8;
  localparam int BYTE_W = 8;
  localparam int DATA_W = 2 * BYTE_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/ram_word_sequencer_if.sv
// Core-side request/response handshake of the word sequencer.
// The core is the master; the sequencer is the slave.
interface ram_word_sequencer_if
  import ram_word_sequencer_pkg::*;
  #(parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W)
  ();

  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic [DATA_WIDTH-1:0] ReqData;
  logic                  RespValid;
  logic                  RespReady;
  logic [DATA_WIDTH-1:0] RespData;
  logic                  RespErr;

  modport master (
    output ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
    input  ReqReady, RespValid, RespData, RespErr
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
    output ReqReady, RespValid, RespData, RespErr
  );

endinterface

// File: rtl/ram_word_sequencer.sv
// Splits one 16-bit load/store into two consecutive byte accesses on an
// asynchronous byte RAM (low byte first) and returns a single response.
module ram_word_sequencer
  import ram_word_sequencer_pkg::*;
  #(parameter int ADDR_WIDTH = ADDR_W,
    parameter int BYTE_WIDTH = BYTE_W,
    parameter int DATA_WIDTH = 2 * BYTE_WIDTH)
  (
    input  logic                  Clock,
    input  logic                  nReset,
    ram_word_sequencer_if.slave   core,
    output logic [ADDR_WIDTH-1:0] RamReadAddr,
    output logic [ADDR_WIDTH-1:0] RamWriteAddr,
    output logic [BYTE_WIDTH-1:0] RamWriteData,
    output logic                  RamWriteEnable,
    input  logic [BYTE_WIDTH-1:0] RamReadData
  );

  state_t                state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] cap_q;

  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [BYTE_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  ram_we_q, ram_we_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // RAM-side values are computed for the state being entered so the RAM
  // sees them straight from flops, without combinational glitches.
  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (core.ReqValid) begin
          if (core.ReqAddr[0]) begin
            state_d = S_RESP;
          end else begin
            state_d    = S_LO;
            ram_addr_d = core.ReqAddr;
            ram_we_d   = core.ReqWrite;
            if (core.ReqWrite) ram_wdata_d = core.ReqData[BYTE_WIDTH-1:0];
          end
        end
      end
      S_LO: begin
        state_d    = S_HI;
        // Aligned address: setting bit 0 never carries, so no wrap.
        ram_addr_d = {addr_q[ADDR_WIDTH-1:1], 1'b1};
        ram_we_d   = wr_q;
        if (wr_q) ram_wdata_d = data_q[DATA_WIDTH-1:BYTE_WIDTH];
      end
      S_HI: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (core.RespReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
    end
  end

  // Request latch and load byte assembly; capture is cleared on accept so
  // stores and errors respond with zero data.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
      cap_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core.ReqValid) begin
            addr_q <= core.ReqAddr;
            wr_q   <= core.ReqWrite;
            data_q <= core.ReqData;
            err_q  <= core.ReqAddr[0];
            cap_q  <= '0;
          end
        end
        S_LO: if (!wr_q) cap_q[BYTE_WIDTH-1:0]          <= RamReadData;
        S_HI: if (!wr_q) cap_q[DATA_WIDTH-1:BYTE_WIDTH] <= RamReadData;
        default: ;
      endcase
    end
  end

  assign RamReadAddr    = ram_addr_q;
  assign RamWriteAddr   = ram_addr_q;
  assign RamWriteData   = ram_wdata_q;
  assign RamWriteEnable = ram_we_q;

  // Ready is gated by reset so every output reads zero while reset is held.
  assign core.ReqReady  = (state_q == S_IDLE) & nReset;
  assign core.RespValid = (state_q == S_RESP);
  assign core.RespData  = (state_q == S_RESP) ? cap_q : '0;
  assign core.RespErr   = (state_q == S_RESP) & err_q;

endmodule

// File: doc/ram_word_sequencer.md
# ram_word_sequencer

Bridges the core's 16-bit load/store port to the byte-wide asynchronous data RAM. Accepts one word request at a time over a valid/ready handshake and splits it into two byte accesses on consecutive cycles, little-endian. Returns load data, or a store completion, on a response handshake. Sits directly upstream of the RAM, between the core's memory stage and the RAM's ReadAddr/WriteAddr/WriteData/WriteEnable/ReadData ports.

## Interface
- ADDR_WIDTH, 8: RAM byte-address width; the request address is a byte address of this width.
- BYTE_WIDTH, 8: RAM word width.
- DATA_WIDTH, 16: core word width; fixed at 2*BYTE_WIDTH.

Ports. One clock; reset is asynchronous and active-low.
- Clock  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  sequencer can accept a request
- ReqWrite  in  1  1 = store, 0 = load
- ReqAddr  in  ADDR_WIDTH  byte address; bit 0 must be 0
- ReqData  in  DATA_WIDTH  store data
- RespValid  out  1  response present
- RespReady  in  1  core accepts response
- RespData  out  DATA_WIDTH  load data; 0 for stores and errors
- RespErr  out  1  misaligned request; no RAM access performed
- RamReadAddr  out  ADDR_WIDTH  to RAM
- RamWriteAddr  out  ADDR_WIDTH  to RAM
- RamWriteData  out  BYTE_WIDTH  to RAM
- RamWriteEnable  out  1  to RAM
- RamReadData  in  BYTE_WIDTH  from RAM; valid in the same cycle its address is presented

## Operation
- States: IDLE, LO, HI, RESP.
- IDLE: ReqReady=1. On ReqValid at a rising edge:
  - latch ReqAddr, ReqWrite and ReqData.
  - If ReqAddr[0]=1, go to RESP with RespErr=1.
  - Otherwise go to LO.
- LO:
  - RamReadAddr = RamWriteAddr = A.
  - Store: RamWriteData = data[7:0], RamWriteEnable = 1.
  - Load: capture RamReadData into the low byte at the closing edge.
  - Next state HI.
- HI:
  - Both RAM addresses = A|1.
  - Store: RamWriteData = data[15:8], RamWriteEnable = 1.
  - Load: capture RamReadData into the high byte.
  - Next state RESP.
- RESP:
  - RespValid=1. RespData = assembled word for loads; 0 for stores and errors.
  - Hold all response outputs stable until RespReady is sampled high, then go to IDLE.
- ReqReady is 0 in LO, HI and RESP. There is no request queue.
- All RAM-side outputs come straight from flops (glitch-free for the asynchronous RAM):
  - they are computed for the next state.
  - outside LO/HI, RamWriteEnable=0 and the addresses and data hold their last values.
- Misaligned request: RamWriteEnable stays 0 and the RAM addresses are not changed.
- Address wrap: aligned A has A|1 ≤ max address, so no carry ever occurs. Address 2^ADDR_WIDTH-2 uses the last two bytes.
- Reset (any state): state goes to IDLE; every output goes to 0.
  - Reset during a store after LO leaves the low byte written and the high byte old. This is accepted behaviour; the core must not rely on atomicity across reset.

## Timing
- Request accepted at edge 0; LO during cycle 1; HI during cycle 2; RespValid rises after edge 2 (error: after edge 0).
- Load latency: 3 cycles from accept to RespValid. Error latency: 1 cycle.
- Minimum occupancy: 4 cycles per word with RespReady held high (accept edge through the response-retire edge).
- RamWriteEnable is high for exactly 2 consecutive cycles per store, never for loads or errors.
- Back-to-back operation: the next request may be accepted on the edge after RESP retires; ReqReady rises in the same cycle RespValid falls.

## Structure
- The shared core package/header holds:
  - the state encoding constants (IDLE=0, LO=1, HI=2, RESP=3).
  - the DATA_WIDTH/BYTE_WIDTH relation.
- Single module, no sub-modules. Byte assembly is inline: a two-byte capture register plus a small FSM.

## Test plan
- Store 0xBEEF to 0x10, then load 0x10:
  - RAM[0x10]=0xEF and RAM[0x11]=0xBE.
  - RespData=0xBEEF with RespErr=0.
  - The load response appears 3 cycles after accept.
- Load from 0x11 → RespValid one cycle after accept, RespErr=1, RespData=0, RamWriteEnable never asserted, RAM unchanged.
- Store 0x1234 to 0xFE, then load → RAM[0xFE]=0x34, RAM[0xFF]=0x12, read back 0x1234, no wrap to 0x00.
- Response back-pressure:
  - Hold RespReady=0 for 5 cycles after a load.
  - Required: RespValid/RespData stable, ReqReady=0, ReqValid ignored.
  - After release, the next request is accepted on the following edge.
- Assert nReset during HI of a store of 0xAAAA over 0x5555 → all outputs 0 immediately, state IDLE, RAM low byte=0xAA, high byte=0x55.
- 20 random aligned store/load pairs with RespReady always 1 → every load matches a reference model; each transaction occupies exactly 4 cycles.
